// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the send-FSM state encoding used by
// the TX FIFO front end and the UART transmitter.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } send_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Synchronous circular-buffer FIFO for the UART TX path. DEPTH must be a power
// of two (>= 2) so the pointers wrap by natural overflow.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [UART_DATA_W-1:0] i_wdata,
    input  logic                   i_pop,
    output logic [UART_DATA_W-1:0] o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [UART_DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [AW:0]            r_count;
    logic [AW:0]            w_count_nxt;
    logic                   r_full;
    logic                   r_empty;
    logic                   w_do_push;
    logic                   w_do_pop;

    // A pop frees a slot, so a push into a full FIFO is still taken when paired with a pop
    always_comb begin
        w_do_pop  = i_pop && !r_empty;
        w_do_push = i_push && (!r_full || w_do_pop);
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and registered flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= CNT_ZERO;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
            r_empty <= (w_count_nxt == CNT_ZERO);
        end
    end

    // Byte storage, deliberately without reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a start_send/done handshake.
// Define UART_TX_FIFO_OVF_EN to add the sticky 'overflow' output.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [UART_DATA_W-1:0] tx_byte,
    output logic                   start_send,
    input  logic                   done
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                   overflow
`endif
);

    send_state_e            r_state;
    send_state_e            w_state_nxt;
    logic                   w_pop;
    logic                   r_avail;
    logic                   r_start_send;
    logic [UART_DATA_W-1:0] r_tx_byte;
    logic [UART_DATA_W-1:0] w_head;

    uart_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_push  (wr_en),
        .i_wdata (wr_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (full),
        .o_empty (empty),
        .o_count (count)
    );

    // Send FSM next-state and pop decode; r_avail is a one-cycle-late view of !empty,
    // which is never stale in IDLE because IDLE is at least two cycles after any pop
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_avail) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: w_state_nxt = WAIT;
            WAIT: begin
                if (done) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and registered transmitter-facing outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_avail      <= 1'b0;
            r_start_send <= 1'b0;
            r_tx_byte    <= {UART_DATA_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_avail      <= !empty;
            r_start_send <= (w_state_nxt == SEND);
            if (w_pop) begin
                r_tx_byte <= w_head;
            end
        end
    end

    assign start_send = r_start_send;
    assign tx_byte    = r_tx_byte;

`ifdef UART_TX_FIFO_OVF_EN
    logic r_overflow;

    // Sticky drop flag: a write lost because the FIFO was full with no pop to free a slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (wr_en && full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo (DEPTH=4); define UART_TX_FIFO_OVF_EN to
// exercise the overflow port as well.
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic [7:0] tx_byte;
    logic       start_send;
    logic       done;
`ifdef UART_TX_FIFO_OVF_EN
    logic       overflow;
`endif

    int         checks = 0;
    int         errors = 0;
    int         n_send = 0;
    int         base;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .tx_byte    (tx_byte),
        .start_send (start_send),
        .done       (done)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_ovf(input string name, input logic req);
`ifdef UART_TX_FIFO_OVF_EN
        chk(name, 32'(overflow), 32'(req));
`endif
    endtask

    // One write strobe; push_exp says whether the byte is expected to emerge later
    task automatic wr(input logic [7:0] b, input bit push_exp);
        wr_en   = 1'b1;
        wr_data = b;
        if (push_exp) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_send(input string tag);
        int n;
        n = 0;
        while (!start_send && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!start_send) begin
            checks++;
            errors++;
            $display("FAIL %s: start_send stayed 0 for 200 cycles, required 1", tag);
        end
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    // Monitor: every start_send pops the scoreboard and checks the presented byte
    initial begin : monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && start_send) begin
                n_send++;
                chk("send_width", 32'(prev), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send: actual tx_byte=%0h required no send", tx_byte);
                end else begin
                    chk("tx_byte_order", 32'(tx_byte), 32'(exp_q.pop_front()));
                end
            end
            prev = start_send;
        end
    end

    initial begin : stimulus
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        done    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_start", 32'(start_send), 32'd0);
        chk("rst_tx", 32'(tx_byte), 32'h00);
        chk_ovf("rst_ovf", 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Latency: write at edge N, send during cycle N+2
        wr(8'h30, 1'b1);
        chk("lat_n_count", 32'(count), 32'd1);
        chk("lat_n_send", 32'(start_send), 32'd0);
        @(negedge clk);
        chk("lat_n1_send", 32'(start_send), 32'd0);
        chk("lat_n1_count", 32'(count), 32'd1);
        @(negedge clk);
        chk("lat_n2_send", 32'(start_send), 32'd1);
        chk("lat_n2_tx", 32'(tx_byte), 32'h30);
        chk("lat_n2_count", 32'(count), 32'd0);
        chk("lat_n2_empty", 32'(empty), 32'd1);
        @(negedge clk);
        chk("wait_send_low", 32'(start_send), 32'd0);
        pulse_done();

        // "ABC" with done 10 cycles after each send
        base = n_send;
        wr(8'h41, 1'b1);
        wr(8'h42, 1'b1);
        wr(8'h43, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_send("abc_send");
            repeat (10) @(negedge clk);
            chk("abc_hold", 32'(tx_byte), 32'(8'h41 + i));
            pulse_done();
            chk("abc_gap_idle", 32'(start_send), 32'd0);
            @(negedge clk);
            chk("abc_gap_send", 32'(start_send), 32'(i < 2));
        end
        repeat (3) @(negedge clk);
        chk("abc_pulses", 32'(n_send - base), 32'd3);
        chk("abc_drained", 32'(exp_q.size()), 32'd0);
        chk("abc_empty", 32'(empty), 32'd1);

        // Fill DEPTH=4 with done held low: A0 goes out, A1..A4 stored, A5/A6 dropped
        wr(8'hA0, 1'b1);
        wr(8'hA1, 1'b1);
        wr(8'hA2, 1'b1);
        wr(8'hA3, 1'b1);
        wr(8'hA4, 1'b1);
        wr(8'hA5, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_empty", 32'(empty), 32'd0);
        chk_ovf("fill_ovf", 1'b1);
        wr(8'hA6, 1'b0);
        chk("drop_count", 32'(count), 32'd4);
        chk_ovf("drop_ovf_sticky", 1'b1);

        // Write while full in the same cycle as a pop
        pulse_done();
        chk("popfull_pre_full", 32'(full), 32'd1);
        wr(8'h55, 1'b1);
        chk("popfull_count", 32'(count), 32'd4);
        chk("popfull_full", 32'(full), 32'd1);
        chk("popfull_send", 32'(start_send), 32'd1);
        for (int i = 0; i < 5; i++) begin
            wait_send("drain_send");
            @(negedge clk);
            pulse_done();
        end
        repeat (3) @(negedge clk);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);

        // Reset during WAIT with three bytes queued
        base = n_send;
        wr(8'hC0, 1'b1);
        wr(8'hC1, 1'b0);
        wr(8'hC2, 1'b0);
        wr(8'hC3, 1'b0);
        chk("mid_count", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_start", 32'(start_send), 32'd0);
        chk("mid_rst_tx", 32'(tx_byte), 32'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_done();
        repeat (8) @(negedge clk);
        chk("mid_rst_sends", 32'(n_send - base), 32'd1);
        chk("mid_rst_still_empty", 32'(empty), 32'd1);
        chk_ovf("mid_rst_ovf", 1'b0);

        // Stream 2*DEPTH+3 bytes across pointer wrap with prompt done
        base = n_send;
        fork
            begin
                for (int i = 0; i < 2 * DEPTH + 3; i++) begin
                    int n;
                    n = 0;
                    while (full && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    if (full) begin
                        checks++;
                        errors++;
                        $display("FAIL stream_full: full stayed 1 for 200 cycles, required 0");
                    end
                    wr(8'(8'h60 + i), 1'b1);
                end
            end
            begin
                for (int j = 0; j < 2 * DEPTH + 3; j++) begin
                    wait_send("stream_send");
                    @(negedge clk);
                    pulse_done();
                end
            end
        join
        repeat (4) @(negedge clk);
        chk("stream_pulses", 32'(n_send - base), 32'(2 * DEPTH + 3));
        chk("stream_left", 32'(exp_q.size()), 32'd0);
        chk("stream_empty", 32'(empty), 32'd1);
        chk_ovf("stream_ovf", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
